// File: rtl/dkong_vram_arb_if.sv
// dkong_vram_arb_if: CPU, hiscore and VRAM bus bundle for the VRAM arbiter.
// slave = arbiter side, master = surrounding system side.
interface dkong_vram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [AW-1:0] I_CPU_AB;
  logic [DW-1:0] I_CPU_DB;
  logic          I_CPU_WRn;
  logic          I_CPU_RDn;
  logic [DW-1:0] O_CPU_DB;
  logic          O_CPU_WAITn;
  logic          I_HS_REQ;
  logic          I_HS_WE;
  logic [AW-1:0] I_HS_AB;
  logic [DW-1:0] I_HS_DB;
  logic          O_HS_ACK;
  logic [DW-1:0] O_HS_DB;
  logic [AW-1:0] O_RAM_AB;
  logic [DW-1:0] O_RAM_DB;
  logic          O_RAM_WE;
  logic [DW-1:0] I_RAM_DB;

  modport slave (
    input  I_CPU_AB, I_CPU_DB, I_CPU_WRn, I_CPU_RDn,
    input  I_HS_REQ, I_HS_WE, I_HS_AB, I_HS_DB,
    input  I_RAM_DB,
    output O_CPU_DB, O_CPU_WAITn,
    output O_HS_ACK, O_HS_DB,
    output O_RAM_AB, O_RAM_DB, O_RAM_WE
  );

  modport master (
    output I_CPU_AB, I_CPU_DB, I_CPU_WRn, I_CPU_RDn,
    output I_HS_REQ, I_HS_WE, I_HS_AB, I_HS_DB,
    output I_RAM_DB,
    input  O_CPU_DB, O_CPU_WAITn,
    input  O_HS_ACK, O_HS_DB,
    input  O_RAM_AB, O_RAM_DB, O_RAM_WE
  );
endinterface

// File: rtl/dkong_vram_arb.sv
// dkong_vram_arb: per-tick slot arbiter for the 1Kx8 tile VRAM (video > CPU > hiscore).
// Define VRAM_ARB_STATS_EN to add the O_CONT_CNT video-contention counter.
module dkong_vram_arb #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic       CLK_24M,
  input  logic       I_RSTn,
  input  logic       CLK_EN,
  input  logic [9:0] I_H_CNT,
  input  logic [7:0] I_VF_CNT,
  input  logic       I_FLIP,
  input  logic       I_CMPBLK,
  dkong_vram_arb_if.slave bus,
  output logic [7:0] O_TILE_CODE,
  output logic       O_ERR
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] O_CONT_CNT
`endif
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    VID,
    CPU,
    HOLD,
    HS
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          cpu_done;
  logic          cpu_done_nx;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] cpu_q;
  logic          vid_slot;
  logic          cpu_wr;
  logic          cpu_req;
  logic          cpu_go;
  logic          hs_go;
  logic          waitn;
  logic [AW-1:0] vid_ab;
  logic          unused;

  assign unused   = ^{I_H_CNT[9], I_VF_CNT[2:0]};
  assign vid_slot = I_CMPBLK & (I_H_CNT[3:0] == 4'h0);
  assign cpu_wr   = ~bus.I_CPU_WRn;
  assign cpu_req  = cpu_wr | ~bus.I_CPU_RDn;
  assign cpu_go   = cpu_req & ~cpu_done & ~vid_slot;
  // back-to-back hiscore grants are blocked while the ack is in flight
  assign hs_go    = bus.I_HS_REQ & (state != HS)
                  & ~vid_slot & ~cpu_go;
  assign waitn    = ~(cpu_req & ~cpu_done);
  assign vid_ab   = AW'({I_VF_CNT[7:3],
                         I_H_CNT[8:4] ^ {5{I_FLIP}}});

  assign bus.O_CPU_WAITn = waitn;
  assign bus.O_CPU_DB    = bus.I_CPU_RDn ? '0 : cpu_q;

  always_comb begin
    cpu_done_nx = cpu_done & cpu_req;
    state_nx    = cpu_done_nx ? HOLD : IDLE;
    unique case (1'b1)
      vid_slot: state_nx = VID;
      cpu_go: begin
        state_nx    = CPU;
        cpu_done_nx = 1'b1;
      end
      hs_go:   state_nx = HS;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state        <= IDLE;
      cpu_done     <= 1'b0;
      wait_cnt     <= '0;
      O_ERR        <= 1'b0;
      cpu_q        <= '0;
      O_TILE_CODE  <= '0;
      bus.O_RAM_AB <= '0;
      bus.O_RAM_DB <= '0;
      bus.O_RAM_WE <= 1'b0;
      bus.O_HS_ACK <= 1'b0;
      bus.O_HS_DB  <= '0;
    end else begin
      bus.O_HS_ACK <= CLK_EN & (state == HS);
      if (CLK_EN) begin
        state        <= state_nx;
        cpu_done     <= cpu_done_nx;
        bus.O_RAM_WE <= 1'b0;
        if (state == VID)
          O_TILE_CODE <= bus.I_RAM_DB[7:0];
        if (state == CPU && !bus.O_RAM_WE)
          cpu_q <= bus.I_RAM_DB;
        if (state == HS)
          bus.O_HS_DB <= bus.I_RAM_DB;
        unique case (state_nx)
          VID: bus.O_RAM_AB <= vid_ab;
          CPU: begin
            bus.O_RAM_AB <= bus.I_CPU_AB;
            bus.O_RAM_WE <= cpu_wr;
            if (cpu_wr)
              bus.O_RAM_DB <= bus.I_CPU_DB;
          end
          HS: begin
            bus.O_RAM_AB <= bus.I_HS_AB;
            bus.O_RAM_WE <= bus.I_HS_WE;
            if (bus.I_HS_WE)
              bus.O_RAM_DB <= bus.I_HS_DB;
          end
          default: ;
        endcase
        if (waitn)
          wait_cnt <= '0;
        else if (wait_cnt != CW'(MAX_WAIT))
          wait_cnt <= wait_cnt + 1'b1;
        if (!waitn && wait_cnt == CW'(MAX_WAIT - 1))
          O_ERR <= 1'b1;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn)
      O_CONT_CNT <= '0;
    else if (CLK_EN & vid_slot & cpu_req & ~cpu_done
             & ~&O_CONT_CNT)
      O_CONT_CNT <= O_CONT_CNT + 16'd1;
  end
`endif
endmodule
